// File: rtl/sample_ascii_framer_if.sv
// Handshake bundle for sample_ascii_framer: sample input, ASCII character stream,
// packed BCD result and status. The slave modport is the framer's view.
interface sample_ascii_framer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIGITS = 3
);
  logic [DATA_W-1:0]   sample_i;
  logic                sample_valid_i;
  logic                sample_ready_o;
  logic [7:0]          char_o;
  logic                char_valid_o;
  logic                char_ready_i;
  logic [4*DIGITS-1:0] bcd_o;
  logic                bcd_valid_o;
  logic                ovf_o;
  logic                busy_o;

  modport slave (
    input  sample_i, sample_valid_i, char_ready_i,
    output sample_ready_o, char_o, char_valid_o, bcd_o, bcd_valid_o, ovf_o, busy_o
  );

  modport master (
    output sample_i, sample_valid_i, char_ready_i,
    input  sample_ready_o, char_o, char_valid_o, bcd_o, bcd_valid_o, ovf_o, busy_o
  );
endinterface

// File: rtl/sample_ascii_framer.sv
// Sample -> double-dabble BCD -> ASCII digit stream plus line terminator.
// Define SAMPLE_ASCII_FRAMER_CRLF_EN for a CR+LF terminator (default: LF only).
module sample_ascii_framer #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned SUPPRESS_ZEROS = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sample_ascii_framer_if.slave bus
);

  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam int unsigned IDX_W   = $clog2(DIGITS + 1);
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT, S_TERM} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BCD_W-1:0]  work;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic [BCD_W-1:0]  bcd_q;
  logic              bcd_valid_q;
  logic              ovf_q;
  logic [3:0]        nib;
  logic [7:0]        char_c;
  logic              conv_done;
  logic              term_last;
  logic [BCD_W-1:0]  bcd_final;
`ifdef SAMPLE_ASCII_FRAMER_CRLF_EN
  logic              term_idx;
`endif

  // One double-dabble step: correct every nibble >= 5, then shift in the next bit.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
    logic [BCD_W-1:0] t;
    t = b;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[BCD_W-2:0], bit_in};
  endfunction

  function automatic logic [IDX_W-1:0] first_digit(input logic [BCD_W-1:0] b);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(DIGITS - 1);
    if (SUPPRESS_ZEROS != 0) begin
      idx = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (b[4*i +: 4] != 4'd0) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  assign conv_done = (cnt == CNT_W'(DATA_W));
  assign bcd_final = ovf_q ? ALL_NINES : work;
`ifdef SAMPLE_ASCII_FRAMER_CRLF_EN
  assign term_last = term_idx;
`else
  assign term_last = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.sample_valid_i) state_nxt = S_CONV;
      S_CONV: if (conv_done) state_nxt = S_EMIT;
      S_EMIT: if (bus.char_ready_i && dig_idx == '0) state_nxt = S_TERM;
      S_TERM: if (bus.char_ready_i && term_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // CONV spends one extra cycle after the last shift to publish bcd_o, which puts
  // the result and the first character DATA_W+1 clocks after the accept edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg       <= '0;
      work        <= '0;
      cnt         <= '0;
      dig_idx     <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SAMPLE_ASCII_FRAMER_CRLF_EN
      term_idx    <= 1'b0;
`endif
    end else begin
      bcd_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.sample_valid_i) begin
            shreg <= bus.sample_i;
            work  <= '0;
            cnt   <= '0;
            ovf_q <= (32'(bus.sample_i) > MAX_VAL);
          end
        end
        S_CONV: begin
          if (!conv_done) begin
            work  <= dabble(work, shreg[DATA_W-1]);
            shreg <= shreg << 1;
            cnt   <= cnt + CNT_W'(1);
          end else begin
            bcd_q       <= bcd_final;
            bcd_valid_q <= 1'b1;
            dig_idx     <= first_digit(bcd_final);
          end
        end
        S_EMIT: begin
          if (bus.char_ready_i && dig_idx != '0) dig_idx <= dig_idx - IDX_W'(1);
`ifdef SAMPLE_ASCII_FRAMER_CRLF_EN
          term_idx <= 1'b0;
`endif
        end
        S_TERM: begin
`ifdef SAMPLE_ASCII_FRAMER_CRLF_EN
          if (bus.char_ready_i) term_idx <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig_idx == IDX_W'(i)) nib = bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    char_c = 8'h00;
    case (state)
      S_EMIT: char_c = {4'h3, nib};
`ifdef SAMPLE_ASCII_FRAMER_CRLF_EN
      S_TERM: char_c = term_idx ? 8'h0A : 8'h0D;
`else
      S_TERM: char_c = 8'h0A;
`endif
      default: char_c = 8'h00;
    endcase
  end

  assign bus.sample_ready_o = (state == S_IDLE);
  assign bus.busy_o         = (state != S_IDLE);
  assign bus.char_valid_o   = (state == S_EMIT) || (state == S_TERM);
  assign bus.char_o         = char_c;
  assign bus.bcd_o          = bcd_q;
  assign bus.bcd_valid_o    = bcd_valid_q;
  assign bus.ovf_o          = ovf_q;

endmodule

// File: tb/tb_sample_ascii_framer.sv
// Bench for sample_ascii_framer: two instances (3 digits / no suppression and
// 2 digits / zero suppression) share stimulus and are scored against an arithmetic model.
module tb_sample_ascii_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       char_ready = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          cyc      = 0;
  int          rmode    = 0;
  int          stall_n  = 0;

  sample_ascii_framer_if #(.DATA_W(8), .DIGITS(3)) if_a ();
  sample_ascii_framer_if #(.DATA_W(8), .DIGITS(2)) if_b ();

  assign if_a.sample_i       = sample;
  assign if_a.sample_valid_i = sample_valid;
  assign if_a.char_ready_i   = char_ready;
  assign if_b.sample_i       = sample;
  assign if_b.sample_valid_i = sample_valid;
  assign if_b.char_ready_i   = char_ready;

  sample_ascii_framer #(.DATA_W(8), .DIGITS(3), .SUPPRESS_ZEROS(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .bus(if_a.slave)
  );
  sample_ascii_framer #(.DATA_W(8), .DIGITS(2), .SUPPRESS_ZEROS(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .bus(if_b.slave)
  );

  logic [7:0]  ch [2];
  logic        cv [2];
  logic        sr [2];
  logic        bv [2];
  logic        ov [2];
  logic        bz [2];
  logic [11:0] bw [2];

  assign ch[0] = if_a.char_o;        assign ch[1] = if_b.char_o;
  assign cv[0] = if_a.char_valid_o;  assign cv[1] = if_b.char_valid_o;
  assign sr[0] = if_a.sample_ready_o; assign sr[1] = if_b.sample_ready_o;
  assign bv[0] = if_a.bcd_valid_o;   assign bv[1] = if_b.bcd_valid_o;
  assign ov[0] = if_a.ovf_o;         assign ov[1] = if_b.ovf_o;
  assign bz[0] = if_a.busy_o;        assign bz[1] = if_b.busy_o;
  assign bw[0] = if_a.bcd_o;         assign bw[1] = {4'h0, if_b.bcd_o};

  logic [7:0]  got_c [2][16];
  int          got_n [2];
  logic [7:0]  exp_c [2][16];
  int          exp_n [2];
  logic [11:0] exp_bcd [2];
  logic        exp_ovf [2];
  int          acc_cyc [2];
  logic        prev_stall [2];
  logic [7:0]  prev_ch [2];
  logic        bv_seen [2];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: decimal digits by division, saturated at 10^D-1, optional zero suppression.
  task automatic model(input int k, input int unsigned s);
    int unsigned nd = (k == 0) ? 3 : 2;
    bit          sz = (k == 1);
    int unsigned mx = 1;
    int unsigned v;
    int unsigned d [8];
    int          st;
    for (int i = 0; i < int'(nd); i++) mx = mx * 10;
    mx = mx - 1;
    exp_ovf[k] = (s > mx);
    v = (s > mx) ? mx : s;
    exp_bcd[k] = '0;
    for (int i = 0; i < int'(nd); i++) begin
      d[i] = v % 10;
      v = v / 10;
      exp_bcd[k] = exp_bcd[k] | (12'(d[i]) << (4 * i));
    end
    st = int'(nd) - 1;
    if (sz) while (st > 0 && d[st] == 0) st--;
    exp_n[k] = 0;
    for (int i = st; i >= 0; i--) begin
      exp_c[k][exp_n[k]] = 8'(32'h30 + d[i]);
      exp_n[k]++;
    end
`ifdef SAMPLE_ASCII_FRAMER_CRLF_EN
    exp_c[k][exp_n[k]] = 8'h0D;
    exp_n[k]++;
`endif
    exp_c[k][exp_n[k]] = 8'h0A;
    exp_n[k]++;
  endtask

  // Monitor: samples at negedge; a transfer seen here completes on the next posedge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) prev_stall[k] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (sample_valid && sr[k]) acc_cyc[k] = cyc + 1;
        if (prev_stall[k]) begin
          check_eq($sformatf("hold_valid[%0d]", k), 32'(cv[k]), 32'd1);
          check_eq($sformatf("hold_char[%0d]", k), 32'(ch[k]), 32'(prev_ch[k]));
        end
        if (bv[k]) begin
          check_eq($sformatf("bcd_latency[%0d]", k), 32'(cyc - acc_cyc[k]), 32'd9);
          check_eq($sformatf("bcd_value[%0d]", k), 32'(bw[k]), 32'(exp_bcd[k]));
          check_eq($sformatf("ovf[%0d]", k), 32'(ov[k]), 32'(exp_ovf[k]));
          check_eq($sformatf("first_char_valid[%0d]", k), 32'(cv[k]), 32'd1);
          bv_seen[k] = 1'b1;
        end
        if (cv[k] && char_ready) begin
          if (got_n[k] < 16) got_c[k][got_n[k]] = ch[k];
          got_n[k]++;
        end
        prev_stall[k] = cv[k] && !char_ready;
        prev_ch[k]    = ch[k];
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      1: char_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (if_a.char_valid_o && if_a.char_o == 8'h33 && stall_n < 5) begin
          char_ready = 1'b0;
          stall_n++;
        end else begin
          char_ready = 1'b1;
        end
      end
      default: char_ready = 1'b1;
    endcase
  end

  task automatic start_frame(input logic [7:0] s);
    model(0, 32'(s));
    model(1, 32'(s));
    for (int k = 0; k < 2; k++) begin got_n[k] = 0; bv_seen[k] = 1'b0; end
    stall_n = 0;
    @(posedge clk); #1;
    sample = s;
    sample_valid = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] s, input bit junk);
    bit ok;
    bit done;
    start_frame(s);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (sr[0] && sr[1]) begin ok = 1'b1; break; end
    end
    check_eq("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (junk && bz[0] && bz[1]) begin
        sample = 8'($urandom);
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      if (!bz[0] && !bz[1]) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    check_eq("frame_timeout", 32'(done), 32'd1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("char_count[%0d] s=%0d", k, s), 32'(got_n[k]), 32'(exp_n[k]));
      for (int i = 0; i < exp_n[k] && i < got_n[k] && i < 16; i++)
        check_eq($sformatf("char[%0d][%0d] s=%0d", k, i, s), 32'(got_c[k][i]), 32'(exp_c[k][i]));
      check_eq($sformatf("bcd_seen[%0d]", k), 32'(bv_seen[k]), 32'd1);
      check_eq($sformatf("bcd_hold[%0d]", k), 32'(bw[k]), 32'(exp_bcd[k]));
      check_eq($sformatf("ovf_hold[%0d]", k), 32'(ov[k]), 32'(exp_ovf[k]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_ready[%0d]", tag, k), 32'(sr[k]), 32'd1);
      check_eq($sformatf("%s_cvalid[%0d]", tag, k), 32'(cv[k]), 32'd0);
      check_eq($sformatf("%s_char[%0d]", tag, k), 32'(ch[k]), 32'd0);
      check_eq($sformatf("%s_bcd[%0d]", tag, k), 32'(bw[k]), 32'd0);
      check_eq($sformatf("%s_bvalid[%0d]", tag, k), 32'(bv[k]), 32'd0);
      check_eq($sformatf("%s_ovf[%0d]", tag, k), 32'(ov[k]), 32'd0);
      check_eq($sformatf("%s_busy[%0d]", tag, k), 32'(bz[k]), 32'd0);
    end
  endtask

  task automatic reset_mid_frame();
    bit seen;
    rmode = 0;
    start_frame(8'd137);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (got_n[0] >= 1) begin seen = 1'b1; break; end
      @(posedge clk);
    end
    check_eq("first_char_before_reset", 32'(seen), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("chars_before_reset", 32'(got_n[0]), 32'd1);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(8'd42, 1'b0);
  endtask

  initial begin
    logic [7:0] s;
    int r;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    rmode = 0;
    run_frame(8'd137, 1'b0);
    run_frame(8'd0,   1'b0);
    run_frame(8'd7,   1'b0);
    run_frame(8'd255, 1'b0);
    run_frame(8'd42,  1'b0);

    rmode = 2;
    run_frame(8'd137, 1'b0);
    check_eq("stall_cycles", 32'(stall_n), 32'd5);

    reset_mid_frame();

    rmode = 0;
    run_frame(8'd200, 1'b1);

    rmode = 1;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0: s = 8'd0;
        1: s = 8'd255;
        2: s = 8'd99;
        3: s = 8'd100;
        default: s = 8'($urandom);
      endcase
      run_frame(s, bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
